// File: rtl/lowx_mem_responder_if.sv
// lowX line link between an initiator (L2 memory port) and a memory responder.
// Request fields flow master->slave, response fields flow slave->master.
interface lowx_mem_responder_if #(
  parameter int BLK_SIZE = 128,
  parameter int XLEN     = 32
);
  logic                req_valid;
  logic [XLEN-1:0]     req_addr;
  logic                req_rw;
  logic [BLK_SIZE-1:0] req_data;
  logic                req_ready;
  logic                res_ready;
  logic                res_valid;
  logic [BLK_SIZE-1:0] res_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data, req_ready,
    input  res_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data, req_ready,
    output res_ready, res_valid, res_data
  );
endinterface

// File: rtl/lowx_mem_responder.sv
// lowX memory-side responder: in-order request queue, fixed latency, held responses.
// Optional LOWX_MEM_STALL_EN adds LFSR-driven ready/valid back-pressure.
//
// state  | meaning
// S_IDLE | no request in flight; pop queue head when present
// S_WAIT | latency countdown; access line store when counter hits 0
// S_RESP | response valid and held until initiator ready
module lowx_mem_responder #(
  parameter int BLK_SIZE = 128,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 1024,
  parameter int LATENCY  = 4,
  parameter int QDEPTH   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  lowx_mem_responder_if.slave  mem_bus,
  output logic                 busy_o
);
  localparam int BOFFSET = $clog2(BLK_SIZE / 8);
  localparam int IW      = $clog2(DEPTH);
  localparam int PW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNTW    = $clog2(QDEPTH + 1);
  localparam int LW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LW-1:0]   LAT_LOAD = LW'(LATENCY - 1);
  localparam logic [CNTW-1:0] Q_FULL   = CNTW'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [LW-1:0]       lat_cnt;
  logic [IW-1:0]       cur_idx;
  logic                cur_rw;
  logic [BLK_SIZE-1:0] cur_data;
  logic                res_valid_q;
  logic [BLK_SIZE-1:0] res_data_q;

  logic [IW-1:0]       q_idx  [QDEPTH];
  logic                q_rw   [QDEPTH];
  logic [BLK_SIZE-1:0] q_data [QDEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CNTW-1:0]     count;

  logic [BLK_SIZE-1:0] line_mem [DEPTH];

  logic stall_ready, stall_valid;
  logic push, pop, hs, access;
  logic unused_addr_bits;

`ifdef LOWX_MEM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall_ready = lfsr[0];
  assign stall_valid = lfsr[1];
`else
  assign stall_ready = 1'b1;
  assign stall_valid = 1'b1;
`endif

  // Ready comes from registered count only; a same-cycle pop does not free a slot.
  assign mem_bus.res_ready = (count != Q_FULL) && stall_ready;
  assign mem_bus.res_valid = res_valid_q && stall_valid;
  assign mem_bus.res_data  = res_data_q;
  assign busy_o            = (count != '0) || (state != S_IDLE);

  assign push   = mem_bus.req_valid && mem_bus.res_ready;
  assign hs     = mem_bus.res_valid && mem_bus.req_ready;
  assign pop    = (count != '0) && ((state == S_IDLE) || ((state == S_RESP) && hs));
  assign access = (state == S_WAIT) && (lat_cnt == '0);

  assign unused_addr_bits = ^mem_bus.req_addr;

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_idx[wr_ptr]  <= mem_bus.req_addr[BOFFSET +: IW];
      q_rw[wr_ptr]   <= mem_bus.req_rw;
      q_data[wr_ptr] <= mem_bus.req_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Line store is deliberately not reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (access && cur_rw) line_mem[cur_idx] <= cur_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      cur_idx     <= '0;
      cur_rw      <= 1'b0;
      cur_data    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_idx  <= q_idx[rd_ptr];
            cur_rw   <= q_rw[rd_ptr];
            cur_data <= q_data[rd_ptr];
            lat_cnt  <= LAT_LOAD;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            res_data_q  <= cur_rw ? '0 : line_mem[cur_idx];
            res_valid_q <= 1'b1;
            state       <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (hs) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              cur_idx  <= q_idx[rd_ptr];
              cur_rw   <= q_rw[rd_ptr];
              cur_data <= q_data[rd_ptr];
              lat_cnt  <= LAT_LOAD;
              state    <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lowx_mem_responder.sv
// Scoreboard bench for lowx_mem_responder: a line-store model predicts each
// response at accept time; responses are compared in order at handshake.
module tb_lowx_mem_responder;
  localparam int BLK  = 128;
  localparam int XL   = 32;
  localparam int DEP  = 1024;
  localparam int LAT  = 4;
  localparam int QD   = 2;
  localparam int BOFF = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic busy_o;

  always #5 clk_i = ~clk_i;

  lowx_mem_responder_if #(.BLK_SIZE(BLK), .XLEN(XL)) mem_bus ();

  lowx_mem_responder #(
    .BLK_SIZE(BLK), .XLEN(XL), .DEPTH(DEP), .LATENCY(LAT), .QDEPTH(QD)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .mem_bus (mem_bus),
    .busy_o  (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_resp   = 0;
  logic [BLK-1:0] exp_q [$];
  logic [BLK-1:0] model [DEP];
  bit rand_phase = 1'b0;
  bit stall_low_empty = 1'b0;

  task automatic check(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic rw, input logic [XL-1:0] addr, input logic [BLK-1:0] data);
    int t = 0;
    mem_bus.req_valid = 1'b1;
    mem_bus.req_rw    = rw;
    mem_bus.req_addr  = addr;
    mem_bus.req_data  = data;
    while (!mem_bus.res_ready && t < 300) begin
      tick();
      t++;
    end
    check("send_accept_in_time", BLK'(t < 300), BLK'(1));
    tick();
    mem_bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_o || exp_q.size() != 0) && t < 3000) begin
      tick();
      t++;
    end
    check("drain_in_time", BLK'(t < 3000), BLK'(1));
  endtask

  // Predict at accept, compare at response handshake.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_bus.req_valid && mem_bus.res_ready) begin
        logic [9:0] idx;
        idx = mem_bus.req_addr[BOFF +: 10];
        if (mem_bus.req_rw) begin
          model[idx] = mem_bus.req_data;
          exp_q.push_back('0);
        end else begin
          exp_q.push_back(model[idx]);
        end
      end
      if (mem_bus.res_valid && mem_bus.req_ready) begin
        check("resp_expected", BLK'(exp_q.size() != 0), BLK'(1));
        if (exp_q.size() != 0) check("resp_data", mem_bus.res_data, exp_q.pop_front());
        n_resp++;
      end
`ifdef LOWX_MEM_STALL_EN
      if (!mem_bus.res_ready && dut.count == '0) stall_low_empty = 1'b1;
`endif
    end
  end

  initial begin
    logic [BLK-1:0] pat_a5;
    int k;
    int resp0;
    pat_a5 = {16{8'hA5}};
    mem_bus.req_valid = 1'b0;
    mem_bus.req_rw    = 1'b0;
    mem_bus.req_addr  = '0;
    mem_bus.req_data  = '0;
    mem_bus.req_ready = 1'b1;
    rst_i = 1'b1;
    tick();
    tick();
    check("rst_valid", BLK'(mem_bus.res_valid), BLK'(0));
    check("rst_data", mem_bus.res_data, '0);
    check("rst_ready", BLK'(mem_bus.res_ready), BLK'(1));
    check("rst_busy", BLK'(busy_o), BLK'(0));
    rst_i = 1'b0;
    tick();

    // Single read with exact latency and held response
    send(1'b1, 32'h40, pat_a5);
    wait_idle();
    mem_bus.req_ready = 1'b0;
    send(1'b0, 32'h40, '0);
    k = 0;
    while (!mem_bus.res_valid && k < 100) begin
      tick();
      k++;
    end
`ifndef LOWX_MEM_STALL_EN
    check("read_latency", BLK'(k), BLK'(LAT + 1));
`endif
    check("read_data", mem_bus.res_data, pat_a5);
`ifndef LOWX_MEM_STALL_EN
    repeat (3) tick();
    check("read_valid_held", BLK'(mem_bus.res_valid), BLK'(1));
    check("read_data_held", mem_bus.res_data, pat_a5);
`endif
    mem_bus.req_ready = 1'b1;
    wait_idle();

    // Queue full: one in flight plus QDEPTH queued
    mem_bus.req_ready = 1'b0;
    send(1'b0, 32'h40, '0);
    send(1'b0, 32'h40, '0);
    send(1'b0, 32'h40, '0);
    check("full_ready_low", BLK'(mem_bus.res_ready), BLK'(0));
    resp0 = n_resp;
    mem_bus.req_valid = 1'b1;
    repeat (8) tick();
    check("full_ready_held_low", BLK'(mem_bus.res_ready), BLK'(0));
    check("full_no_resp", BLK'(n_resp), BLK'(resp0));
    mem_bus.req_ready = 1'b1;
    send(1'b0, 32'h4040, '0);
    wait_idle();

    // RAW ordering on the same line
    resp0 = n_resp;
    send(1'b1, 32'h80, BLK'(16'h1234));
    send(1'b0, 32'h80, '0);
    wait_idle();
    check("raw_resp_count", BLK'(n_resp - resp0), BLK'(2));

    // Address wrap beyond DEPTH lines
    send(1'b1, 32'h40 + (32'd1024 << BOFF), {4{32'hDEADBEEF}});
    send(1'b0, 32'h40, '0);
    wait_idle();

    // Reset during WAIT drops the outstanding read
    send(1'b0, 32'h80, '0);
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", BLK'(mem_bus.res_valid), BLK'(0));
    check("mid_rst_ready", BLK'(mem_bus.res_ready), BLK'(1));
    check("mid_rst_busy", BLK'(busy_o), BLK'(0));
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    resp0 = n_resp;
    repeat (20) tick();
    check("no_stale_resp", BLK'(n_resp), BLK'(resp0));

    // Random traffic over 8 lines with random upper address bits
    for (int i = 0; i < 8; i++)
      send(1'b1, XL'(i) << BOFF, {$urandom, $urandom, $urandom, $urandom});
    wait_idle();
    rand_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [XL-1:0] a;
          a = ($urandom & ~32'h3FF0) | (XL'($urandom_range(0, 7)) << BOFF);
          send(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          tick();
          mem_bus.req_ready = ($urandom_range(0, 3) != 0);
        end
        mem_bus.req_ready = 1'b1;
      end
    join
    mem_bus.req_ready = 1'b1;
    wait_idle();

`ifdef LOWX_MEM_STALL_EN
    check("stall_ready_low_seen", BLK'(stall_low_empty), BLK'(1));
`endif
    check("scoreboard_empty", BLK'(exp_q.size()), BLK'(0));
    check("resp_count", BLK'(n_resp), BLK'(118));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
